// File: rtl/alarm_annunciator.sv
// alarm_annunciator: beep-cadence tone generator with level escalation and LED bar.
// Snooze (SNOOZE state and its timing) is built only when ALARM_SNOOZE_EN is defined.
module alarm_annunciator #(
    parameter int unsigned TONE_DIV   = 8,
    parameter int unsigned BEEP_ON    = 16,
    parameter int unsigned BEEP_OFF   = 16,
    parameter int unsigned ESC_BEEPS  = 4,
    parameter int unsigned SNOOZE_CYC = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       alert_i,
    input  logic       ack_i,
    input  logic       snooze_i,
    output logic       tone_o,
    output logic [3:0] led_o,
    output logic [1:0] level_o,
    output logic [1:0] state_o
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ON   = 2'd1;
    localparam logic [1:0] S_OFF  = 2'd2;
    localparam logic [1:0] S_SNZ  = 2'd3;

    logic [1:0]  state_q, state_d, level_q, level_d;
    logic [7:0]  beep_q, beep_d;
    logic [15:0] phase_q, phase_d, tcnt_q, tcnt_d, half, lim;
    logic [3:0]  led_q, led_d;
    logic        tone_q, tone_d, snz, expire;

`ifdef ALARM_SNOOZE_EN
    assign snz = snooze_i;
`else
    logic unused_snooze;
    assign snz = 1'b0;
    assign unused_snooze = snooze_i;
`endif

    // One phase counter times ON, OFF and SNOOZE against a per-state limit
    assign lim    = state_q == S_ON  ? 16'(BEEP_ON - 1)
                  : state_q == S_OFF ? 16'(BEEP_OFF - 1) : 16'(SNOOZE_CYC - 1);
    assign expire = phase_q == lim;
    assign half   = 16'(TONE_DIV >> level_q);

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        beep_d  = beep_q;
        phase_d = phase_q + 16'd1;
        tcnt_d  = 16'd0;
        tone_d  = 1'b0;
        if (state_q == S_IDLE) begin
            state_d = alert_i ? S_ON : S_IDLE;
            level_d = 2'd0;
            beep_d  = 8'd0;
            phase_d = 16'd0;
        end else if (ack_i || !alert_i) begin
            state_d = S_IDLE;
            level_d = 2'd0;
            beep_d  = 8'd0;
            phase_d = 16'd0;
        end else if (snz && state_q != S_SNZ) begin
            state_d = S_SNZ;
            phase_d = 16'd0;
        end else if (expire) begin
            phase_d = 16'd0;
            state_d = state_q == S_ON ? S_OFF : S_ON;
            if (state_q == S_ON)
                beep_d = beep_q + 8'd1;
            if (state_q == S_OFF && beep_q == 8'(ESC_BEEPS)) begin
                beep_d  = 8'd0;
                level_d = level_q == 2'd3 ? 2'd3 : level_q + 2'd1;
            end
        end else if (state_q == S_ON) begin
            tone_d = tcnt_q == half - 16'd1 ? ~tone_q : tone_q;
            tcnt_d = tcnt_q == half - 16'd1 ? 16'd0 : tcnt_q + 16'd1;
        end
        led_d = state_d == S_IDLE ? 4'd0
              : {level_d == 2'd3, level_d[1], level_d != 2'd0, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            level_q <= 2'd0;
            beep_q  <= 8'd0;
            phase_q <= 16'd0;
            tcnt_q  <= 16'd0;
            tone_q  <= 1'b0;
            led_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            beep_q  <= beep_d;
            phase_q <= phase_d;
            tcnt_q  <= tcnt_d;
            tone_q  <= tone_d;
            led_q   <= led_d;
        end
    end

    assign tone_o  = tone_q;
    assign led_o   = led_q;
    assign level_o = level_q;
    assign state_o = state_q;
endmodule
